// File: rtl/aes_pkg.sv
// Shared AES datapath constants, byte-index type and output-serializer state encoding.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTE_W  = 8;
  localparam int AES_NBYTES  = 16;

  typedef logic [$clog2(AES_NBYTES)-1:0] aes_byte_idx_t;

  typedef enum logic [0:0] {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/aes_out_serializer.sv
// Two-deep block-to-byte serializer (active shifter + one hold register), gapless at 1 byte/cycle.
// Optional AES_OUT_LAST_EN adds a dout_last port flagging the final byte of each block.
module aes_out_serializer
  import aes_pkg::*;
#(
  parameter int BLOCK_BYTES = AES_NBYTES
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [AES_BYTE_W*BLOCK_BYTES-1:0] blk_in,
  input  logic                           blk_valid,
  output logic                           blk_ready,
  output logic [AES_BYTE_W-1:0]          dout,
  output logic                           dout_valid,
  input  logic                           dout_ready,
  output logic                           busy
`ifdef AES_OUT_LAST_EN
  ,
  output logic                           dout_last
`endif
);

  localparam int BLK_W = AES_BYTE_W * BLOCK_BYTES;
  localparam int CNT_W = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_BYTES - 1);

  ser_state_e       state;
  logic [BLK_W-1:0] shifter;
  logic [BLK_W-1:0] hold;
  logic             hold_valid;
  logic [CNT_W-1:0] cnt;

  logic blk_acc;
  logic byte_acc;
  logic last_byte;

  // The hold register is the only thing that can refuse a block, so ready never looks at valid.
  assign blk_ready  = !hold_valid;
  assign dout_valid = (state == SER_SHIFT);
  assign dout       = dout_valid ? shifter[BLK_W-1 -: AES_BYTE_W] : '0;
  assign busy       = (state == SER_SHIFT) || hold_valid;

  assign blk_acc   = blk_valid && blk_ready;
  assign byte_acc  = dout_valid && dout_ready;
  assign last_byte = (cnt == CNT_LAST);

`ifdef AES_OUT_LAST_EN
  assign dout_last = dout_valid && last_byte;
`endif

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SER_IDLE;
      shifter    <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        SER_IDLE: begin
          if (blk_acc) begin
            shifter <= blk_in;
            cnt     <= '0;
            state   <= SER_SHIFT;
          end
        end

        SER_SHIFT: begin
          if (byte_acc && last_byte) begin
            // Refill on the last-byte edge so the next block follows with no bubble.
            cnt <= '0;
            if (hold_valid) begin
              shifter    <= hold;
              hold_valid <= 1'b0;
            end else if (blk_acc) begin
              shifter <= blk_in;
            end else begin
              state <= SER_IDLE;
            end
          end else begin
            if (byte_acc) begin
              shifter <= {shifter[BLK_W-AES_BYTE_W-1:0], {AES_BYTE_W{1'b0}}};
              cnt     <= cnt + CNT_W'(1);
            end
            if (blk_acc) begin
              hold       <= blk_in;
              hold_valid <= 1'b1;
            end
          end
        end

        default: state <= SER_IDLE;
      endcase
    end
  end

endmodule
